// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store bus master: access sizes, bus WLEN codes,
// sequencer states and the request legality rule.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] WLEN_READ = 2'b00;
  localparam logic [1:0] WLEN_B    = 2'b01;
  localparam logic [1:0] WLEN_H    = 2'b10;
  localparam logic [1:0] WLEN_W    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // A request is rejected without touching the bus when its size code is
  // undefined or its address is not naturally aligned to that size.
  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] lane);
    return (size == 2'd3) ||
           (size == SZ_HALF && lane[0]) ||
           (size == SZ_WORD && lane != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: picks the addressed byte/half out of the bus
// word and sign- or zero-extends it to 32 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic signed [7:0]  byte_val;
  logic signed [15:0] half_val;

  always_comb begin
    byte_val = 8'sd0;
    unique case (lane)
      2'd0:    byte_val = $signed(rdata[7:0]);
      2'd1:    byte_val = $signed(rdata[15:8]);
      2'd2:    byte_val = $signed(rdata[23:16]);
      default: byte_val = $signed(rdata[31:24]);
    endcase
    half_val = lane[1] ? $signed(rdata[31:16]) : $signed(rdata[15:0]);

    result = rdata;
    if (size == SZ_BYTE) begin
      result = uns ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
    end else if (size == SZ_HALF) begin
      result = uns ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
    end
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Single-outstanding load/store sequencer driving the memory bus (IDLE, ISSUE,
// WAIT, RESP). Optional bus timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] bus_address,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_wlen,
  output logic        bus_en_n,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  if (TIMEOUT_CYCLES >= (1 << TO_W)) begin : g_bad_cfg
    $error("TO_W too narrow to hold TIMEOUT_CYCLES");
  end

  state_t      state;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic [31:0] load_data;

`ifdef LSU_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
`endif

  lsu_load_align u_align (
    .rdata  (bus_rdata),
    .lane   (lane_q),
    .size   (size_q),
    .uns    (uns_q),
    .result (load_data)
  );

  // Request attributes are captured at acceptance; the lane/size/sign fields
  // steer the aligner when the bus answers.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req_valid) begin
      lane_q <= req_addr[1:0];
      size_q <= req_size;
      we_q   <= req_we;
      uns_q  <= req_unsigned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      bus_en_n    <= 1'b1;
      bus_wlen    <= WLEN_READ;
      bus_address <= '0;
      bus_wdata   <= '0;
`ifdef LSU_TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (req_illegal(req_size, req_addr[1:0])) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state    <= ST_ISSUE;
              bus_en_n <= 1'b0;
              if (req_we) begin
                bus_address <= req_addr;
                bus_wdata   <= req_wdata;
                bus_wlen    <= req_size + 2'd1;
              end else begin
                bus_address <= {req_addr[31:2], 2'b00};
                bus_wlen    <= WLEN_READ;
              end
            end
          end
        end
        // READY may still be high from the previous access, so it is not
        // looked at until the first WAIT cycle.
        ST_ISSUE: begin
          state <= ST_WAIT;
`ifdef LSU_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (bus_ready) begin
            state      <= ST_RESP;
            bus_en_n   <= 1'b1;
            bus_wlen   <= WLEN_READ;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= we_q ? 32'd0 : load_data;
          end
`ifdef LSU_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state      <= ST_RESP;
            bus_en_n   <= 1'b1;
            bus_wlen   <= WLEN_READ;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            to_cnt     <= to_cnt + 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state      <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- CPU-side load/store sequencer, directly upstream of the memory bus (SDRAM / LED / VGA decode).
- Accepts one load or store at a time from the CPU memory stage and converts it into a bus transaction on address / wdata / WLEN / EN_N.
- Waits for READY, then for loads extracts the addressed byte, half or word and sign- or zero-extends it. Returns a single-cycle response to the CPU.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles waited for bus READY before the access is aborted with an error. Only used with LSU_TIMEOUT_EN.
- TO_W, 8: counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  in  1  load zero-extends when set, sign-extends when clear.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle pulse when the access completes.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid: misaligned, illegal size or timeout.
- bus_address  out  32  to bus address.
- bus_wdata  out  32  to bus wdata.
- bus_wlen  out  2  to bus WLEN: 00 read, 01 byte write, 10 half write, 11 word write.
- bus_en_n  out  1  to bus EN_N, active low.
- bus_ready  in  1  bus READY (level signal, may remain high from the previous access).
- bus_rdata  in  32  bus rdata.

Behaviour:
- Reset values:
  - State IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - bus_en_n=1, bus_wlen=00, bus_address=0, bus_wdata=0.
  - Timeout counter 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1. The request is accepted on the cycle where req_valid=1.
  - Accept registers addr, size, we, unsigned and wdata.
  - Illegal request goes straight to RESP with err=1 and no bus activity. Illegal means:
    - size=3;
    - size=1 with addr[0]≠0;
    - size=2 with addr[1:0]≠0.
  - Legal request goes to ISSUE.
- ISSUE (one cycle):
  - bus_en_n=0.
  - Loads: bus_address = {addr[31:2],2'b00}, bus_wlen=00.
  - Stores: bus_address = addr, bus_wdata = wdata, bus_wlen = size+1.
  - bus_ready is ignored in this cycle because it may be stale. Next state is WAIT.
- WAIT:
  - Bus outputs held stable, bus_en_n=0.
  - On bus_ready=1: capture bus_rdata, set bus_en_n=1 and bus_wlen=00, go to RESP.
- Load extraction uses lane = addr[1:0]:
  - byte = bus_rdata[8*lane +: 8]
  - half = bus_rdata[16*addr[1] +: 16]
  - word = bus_rdata
  - Bit 7 or bit 15 is replicated when req_unsigned=0; zeros are filled otherwise.
- RESP (one cycle): resp_valid=1 with resp_rdata and resp_err valid, req_ready=0. Next state is IDLE.
- Minimum latency:
  - Legal access: 4 cycles from acceptance to resp_valid (ISSUE, WAIT with ready, RESP).
  - Illegal request: 2 cycles.
- No pipelining; req_valid is ignored outside IDLE.
- Reset asserted mid-operation: immediate return to reset values. bus_en_n is high on the next edge and no response is issued.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - Counter clears in ISSUE and increments each WAIT cycle without bus_ready.
  - When the count reaches TIMEOUT_CYCLES, the unit releases the bus (bus_en_n=1) and goes to RESP with resp_err=1 and resp_rdata=0.
  - If bus_ready and the timeout coincide, bus_ready wins.
- Undefined: WAIT lasts indefinitely; no counter logic exists.

Decomposition:
- Package lsu_pkg holds:
  - the size encodings SZ_BYTE, SZ_HALF and SZ_WORD;
  - the WLEN encodings WLEN_READ, WLEN_B, WLEN_H and WLEN_W;
  - the state enum.
- Sub-module lsu_load_align: purely combinational lane select and sign/zero extension (rdata, lane, size, unsigned → 32-bit result).

Test Plan:
- Word store at addr 0x100, data 0xDEADBEEF, bus_ready high 3 cycles after ISSUE:
  - bus_wlen=11, bus_address=0x100, bus_en_n low exactly 4 cycles;
  - resp_valid with err=0, rdata=0.
- Signed byte load at addr 0x103, bus_rdata=0x80112233: bus_address=0x100, bus_wlen=00, resp_rdata=0xFFFFFF80. The same access unsigned gives 0x00000080.
- Half load at addr 0x2, bus_rdata=0x7FFF1234: signed gives 0x00007FFF; an unsigned half at addr 0x0 gives 0x00001234.
- Word load at 0x101, then size=3 at 0x0: each gives resp_err=1 two cycles after acceptance, with bus_en_n never asserted.
- Stale ready: bus_ready held high from the previous access through ISSUE. The response must still take 4 cycles, with no early capture in ISSUE.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=5, bus_ready held low: resp_err=1 after the 5-cycle timeout and bus_en_n released. Separately, asserting rst during WAIT gives bus_en_n=1 and req_ready=1 next cycle with no resp_valid.
